// File: rtl/dram_refresh_arbiter.sv
// CAS-before-RAS refresh scheduler and CPU/refresh arbiter for the Mackerel-30 DRAM.
// Every output is a flop loaded from the next-state decode, so strobes never glitch.
module dram_refresh_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_PENDING      = 4,
  parameter int CAS_SETUP        = 1,
  parameter int RAS_WIDTH        = 3,
  parameter int PRECHARGE        = 2
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       CS_n,
  input  logic       AS_n,
  output logic       CPU_GO,
  output logic       REF_ACTIVE,
  output logic       REF_RAS_n,
  output logic       REF_CAS_n,
  output logic [2:0] REF_PENDING,
  output logic       REF_OVERFLOW
);

  localparam int CNT_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int DUR_A   = (CAS_SETUP > RAS_WIDTH) ? CAS_SETUP : RAS_WIDTH;
  localparam int MAX_DUR = (DUR_A > PRECHARGE) ? DUR_A : PRECHARGE;
  localparam int TMR_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]       PEND_MAX = 3'(MAX_PENDING);
  localparam logic [TMR_W-1:0] T_CAS    = TMR_W'(CAS_SETUP - 1);
  localparam logic [TMR_W-1:0] T_RAS    = TMR_W'(RAS_WIDTH - 1);
  localparam logic [TMR_W-1:0] T_PRE    = TMR_W'(PRECHARGE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU,
    CPU_PRE,
    REF_CAS,
    REF_RAS,
    REF_PRE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             cpu_go_q, cpu_go_d;
  logic             ref_active_q, ref_active_d;
  logic             ras_n_q, ras_n_d;
  logic             cas_n_q, cas_n_d;

  logic cpu_req;
  logic tick;
  logic timer_done;
  logic ras_exit;

  always_comb begin
    cpu_req    = !CS_n && !AS_n;
    tick       = (cnt_q == CNT_LAST);
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    timer_done = (timer_q == '0);
    ras_exit   = (state_q == REF_RAS) && timer_done;

    state_d = state_q;
    timer_d = timer_done ? timer_q : timer_q - TMR_W'(1);

    // The timer is reloaded with (duration - 1) on every state entry.
    case (state_q)
      IDLE: begin
        if (pending_q == PEND_MAX) begin
          state_d = REF_CAS;
          timer_d = T_CAS;
        end else if (cpu_req) begin
          state_d = CPU;
          timer_d = '0;
        end else if (pending_q != 3'd0) begin
          state_d = REF_CAS;
          timer_d = T_CAS;
        end
      end
      CPU: begin
        if (!cpu_req) begin
          state_d = CPU_PRE;
          timer_d = T_PRE;
        end
      end
      CPU_PRE: begin
        if (timer_done) state_d = IDLE;
      end
      REF_CAS: begin
        if (timer_done) begin
          state_d = REF_RAS;
          timer_d = T_RAS;
        end
      end
      REF_RAS: begin
        if (timer_done) begin
          state_d = REF_PRE;
          timer_d = T_PRE;
        end
      end
      REF_PRE: begin
        if (timer_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // A tick and a completed refresh on the same edge cancel out.
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (tick && !ras_exit) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 3'd1;
    end else if (ras_exit && !tick) begin
      pending_d = pending_q - 3'd1;
    end

    cpu_go_d     = (state_d == CPU);
    ref_active_d = (state_d == REF_CAS) || (state_d == REF_RAS) || (state_d == REF_PRE);
    cas_n_d      = !((state_d == REF_CAS) || (state_d == REF_RAS));
    ras_n_d      = !(state_d == REF_RAS);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      pending_q    <= 3'd0;
      overflow_q   <= 1'b0;
      cpu_go_q     <= 1'b0;
      ref_active_q <= 1'b0;
      ras_n_q      <= 1'b1;
      cas_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      cpu_go_q     <= cpu_go_d;
      ref_active_q <= ref_active_d;
      ras_n_q      <= ras_n_d;
      cas_n_q      <= cas_n_d;
    end
  end

  assign CPU_GO       = cpu_go_q;
  assign REF_ACTIVE   = ref_active_q;
  assign REF_RAS_n    = ras_n_q;
  assign REF_CAS_n    = cas_n_q;
  assign REF_PENDING  = pending_q;
  assign REF_OVERFLOW = overflow_q;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Bench for dram_refresh_arbiter: two instances (debt limit 4 and 2) share one stimulus
// stream and are compared each cycle against an activity/age reference model.
module tb_dram_refresh_arbiter;

  localparam int INTERVAL = 16;
  localparam int CAS      = 1;
  localparam int RASW     = 3;
  localparam int PRE      = 2;

  localparam int M_IDLE    = 0;
  localparam int M_CPU     = 1;
  localparam int M_CPU_PRE = 2;
  localparam int M_REF     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic as_n = 1'b1;

  logic       go    [2];
  logic       act   [2];
  logic       ras_n [2];
  logic       cas_n [2];
  logic [2:0] pend  [2];
  logic       ovf   [2];

  int checks = 0;
  int errors = 0;

  int m_mode [2];
  int m_age  [2];
  int m_cnt  [2];
  int m_pend [2];
  int m_ovf  [2];
  int p_max  [2];
  int prev_ras [2];

  always #5 clk = ~clk;

  dram_refresh_arbiter #(
    .REFRESH_INTERVAL(INTERVAL), .MAX_PENDING(4),
    .CAS_SETUP(CAS), .RAS_WIDTH(RASW), .PRECHARGE(PRE)
  ) dut_a (
    .CLK(clk), .RST_n(rst_n), .CS_n(cs_n), .AS_n(as_n),
    .CPU_GO(go[0]), .REF_ACTIVE(act[0]), .REF_RAS_n(ras_n[0]), .REF_CAS_n(cas_n[0]),
    .REF_PENDING(pend[0]), .REF_OVERFLOW(ovf[0])
  );

  dram_refresh_arbiter #(
    .REFRESH_INTERVAL(INTERVAL), .MAX_PENDING(2),
    .CAS_SETUP(CAS), .RAS_WIDTH(RASW), .PRECHARGE(PRE)
  ) dut_b (
    .CLK(clk), .RST_n(rst_n), .CS_n(cs_n), .AS_n(as_n),
    .CPU_GO(go[1]), .REF_ACTIVE(act[1]), .REF_RAS_n(ras_n[1]), .REF_CAS_n(cas_n[1]),
    .REF_PENDING(pend[1]), .REF_OVERFLOW(ovf[1])
  );

  typedef struct {
    bit rstn;
    bit cs;
    bit as;
    int go;
    int act;
    int ras;
    int cas;
    int pend;
  } vec_t;

  vec_t tbl [11];

  task automatic check1(input string name, input int k, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s inst%0d got %0d want %0d at %0t", name, k, got, want, $time);
    end
  endtask

  // Refresh is one activity of CAS+RASW+PRE cycles; strobes follow from its age.
  task automatic modelStep(input int k, input bit rstn, input bit req);
    bit tick;
    bit rexit;
    int nmode;
    int nage;
    int d;
    if (!rstn) begin
      m_mode[k] = M_IDLE; m_age[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_ovf[k] = 0;
    end else begin
      tick = (m_cnt[k] == INTERVAL - 1);
      m_cnt[k] = (m_cnt[k] + 1) % INTERVAL;
      rexit = (m_mode[k] == M_REF) && (m_age[k] == CAS + RASW - 1);
      nmode = m_mode[k];
      nage = m_age[k] + 1;
      case (m_mode[k])
        M_IDLE: begin
          nage = 0;
          if (m_pend[k] == p_max[k]) nmode = M_REF;
          else if (req) nmode = M_CPU;
          else if (m_pend[k] > 0) nmode = M_REF;
        end
        M_CPU: if (!req) begin nmode = M_CPU_PRE; nage = 0; end
        M_CPU_PRE: if (m_age[k] == PRE - 1) nmode = M_IDLE;
        default: if (m_age[k] == CAS + RASW + PRE - 1) nmode = M_IDLE;
      endcase
      d = m_pend[k] + int'(tick) - int'(rexit);
      if (d > p_max[k]) begin
        d = p_max[k];
        m_ovf[k] = 1;
      end
      m_pend[k] = d;
      m_mode[k] = nmode;
      m_age[k] = nage;
    end
  endtask

  task automatic checkOutput(input int k);
    int in_ref;
    in_ref = (m_mode[k] == M_REF) ? 1 : 0;
    check1("cpu_go", k, int'(go[k]), (m_mode[k] == M_CPU) ? 1 : 0);
    check1("ref_active", k, int'(act[k]), in_ref);
    check1("ref_cas_n", k, int'(cas_n[k]), (in_ref == 1 && m_age[k] < CAS + RASW) ? 0 : 1);
    check1("ref_ras_n", k, int'(ras_n[k]),
           (in_ref == 1 && m_age[k] >= CAS && m_age[k] < CAS + RASW) ? 0 : 1);
    check1("ref_pending", k, int'(pend[k]), m_pend[k]);
    check1("ref_overflow", k, int'(ovf[k]), m_ovf[k]);
    check1("go_and_active", k, int'(go[k] & act[k]), 0);
    if (prev_ras[k] == 1 && ras_n[k] == 1'b0)
      check1("ras_fall_cas_high", k, int'(cas_n[k]), 0);
    prev_ras[k] = int'(ras_n[k]);
  endtask

  task automatic applyStimulus(input bit rstn, input bit cs, input bit as);
    @(negedge clk);
    rst_n = rstn;
    cs_n = cs;
    as_n = as;
    @(posedge clk);
    for (int k = 0; k < 2; k++) modelStep(k, rstn, !cs && !as);
    #1;
    for (int k = 0; k < 2; k++) checkOutput(k);
  endtask

  task automatic expectBoth(input string name, input int sel, input int want);
    for (int k = 0; k < 2; k++) begin
      case (sel)
        0: check1(name, k, int'(go[k]), want);
        1: check1(name, k, int'(act[k]), want);
        2: check1(name, k, int'(ras_n[k]), want);
        3: check1(name, k, int'(cas_n[k]), want);
        4: check1(name, k, int'(pend[k]), want);
        default: check1(name, k, int'(ovf[k]), want);
      endcase
    end
  endtask

  initial begin
    int hold_left;
    bit rq;
    bit cs_r;
    bit as_r;
    int pat;

    p_max[0] = 4; p_max[1] = 2;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_age[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_ovf[k] = 0;
      prev_ras[k] = 1;
    end

    // Reset, a 5-cycle CPU access, its precharge, and lone CS_n / AS_n.
    tbl[0]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 1, 1, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 0, 1, 1, 0};
    tbl[4]  = '{1, 0, 0, 1, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 1, 0, 1, 1, 0};
    tbl[6]  = '{1, 1, 1, 0, 0, 1, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 1, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 1, 1, 0};
    tbl[9]  = '{1, 0, 1, 0, 0, 1, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 1, 1, 0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rstn, tbl[i].cs, tbl[i].as);
      expectBoth("tbl_cpu_go", 0, tbl[i].go);
      expectBoth("tbl_ref_active", 1, tbl[i].act);
      expectBoth("tbl_ras_n", 2, tbl[i].ras);
      expectBoth("tbl_cas_n", 3, tbl[i].cas);
      expectBoth("tbl_pending", 4, tbl[i].pend);
    end

    // Idle refresh: tick on the 16th edge, then CAS 1, RAS+CAS 3, precharge 2.
    applyStimulus(0, 1, 1);
    repeat (15) applyStimulus(1, 1, 1);
    expectBoth("t1_pend_before_tick", 4, 0);
    applyStimulus(1, 1, 1);
    expectBoth("t1_pend_after_tick", 4, 1);
    expectBoth("t1_idle_act", 1, 0);
    applyStimulus(1, 1, 1);
    expectBoth("t1_cas_phase_cas", 3, 0);
    expectBoth("t1_cas_phase_ras", 2, 1);
    expectBoth("t1_cas_phase_act", 1, 1);
    repeat (3) applyStimulus(1, 1, 1);
    expectBoth("t1_ras_phase_ras", 2, 0);
    expectBoth("t1_ras_phase_pend", 4, 1);
    applyStimulus(1, 1, 1);
    expectBoth("t1_pre_pend", 4, 0);
    expectBoth("t1_pre_ras", 2, 1);
    expectBoth("t1_pre_act", 1, 1);
    applyStimulus(1, 1, 1);
    expectBoth("t1_pre2_act", 1, 1);
    applyStimulus(1, 1, 1);
    expectBoth("t1_back_idle_act", 1, 0);

    // CPU held across three ticks; the limit-2 instance saturates.
    applyStimulus(0, 1, 1);
    repeat (50) applyStimulus(1, 0, 0);
    check1("t3_pend", 0, int'(pend[0]), 3);
    check1("t3_ovf", 0, int'(ovf[0]), 0);
    check1("t4_pend_sat", 1, int'(pend[1]), 2);
    check1("t4_ovf_sticky", 1, int'(ovf[1]), 1);
    expectBoth("t3_cpu_held", 0, 1);
    applyStimulus(1, 1, 1);
    expectBoth("t3_release_go", 0, 0);
    repeat (2) applyStimulus(1, 0, 0);
    expectBoth("t4_pre_ignores_req", 0, 0);
    applyStimulus(1, 0, 0);
    check1("t4_a_grant", 0, int'(go[0]), 1);
    check1("t4_b_refresh_first", 1, int'(act[1]), 1);
    check1("t4_b_cas", 1, int'(cas_n[1]), 0);
    repeat (3) applyStimulus(1, 0, 0);
    check1("t4_b_ras", 1, int'(ras_n[1]), 0);
    applyStimulus(1, 0, 0);
    check1("t4_b_pend_dec", 1, int'(pend[1]), 1);
    repeat (2) applyStimulus(1, 0, 0);
    check1("t4_b_idle", 1, int'(act[1]), 0);
    applyStimulus(1, 0, 0);
    check1("t4_b_grant", 1, int'(go[1]), 1);
    check1("t4_a_still_cpu", 0, int'(go[0]), 1);
    repeat (9) applyStimulus(1, 0, 0);
    check1("t4_a_cpu_not_aborted", 0, int'(go[0]), 1);
    repeat (80) applyStimulus(1, 1, 1);

    // Tick lands on the RAS exit edge: debt unchanged.
    applyStimulus(0, 1, 1);
    expectBoth("t4_reset_clears_ovf", 5, 0);
    repeat (24) applyStimulus(1, 0, 0);
    repeat (7) applyStimulus(1, 1, 1);
    expectBoth("t5_in_ras", 2, 0);
    expectBoth("t5_pend_before", 4, 1);
    applyStimulus(1, 1, 1);
    expectBoth("t5_pend_tick_exit", 4, 1);
    expectBoth("t5_pre_ras", 2, 1);
    repeat (10) applyStimulus(1, 1, 1);
    expectBoth("t5_drained", 4, 0);

    // Reset in the middle of RAS releases strobes and restarts the interval.
    applyStimulus(0, 1, 1);
    repeat (18) applyStimulus(1, 1, 1);
    expectBoth("t6_in_ras", 2, 0);
    applyStimulus(0, 1, 1);
    expectBoth("t6_ras_released", 2, 1);
    expectBoth("t6_cas_released", 3, 1);
    expectBoth("t6_act_clear", 1, 0);
    expectBoth("t6_pend_clear", 4, 0);
    expectBoth("t6_ovf_clear", 5, 0);
    repeat (15) applyStimulus(1, 1, 1);
    expectBoth("t6_no_early_tick", 4, 0);
    applyStimulus(1, 1, 1);
    expectBoth("t6_tick_restart", 4, 1);

    // Random bursty traffic with rare resets against the model.
    hold_left = 0;
    cs_r = 1'b1;
    as_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (hold_left == 0) begin
        rq = ($urandom_range(0, 2) != 0);
        if (rq) begin
          cs_r = 1'b0;
          as_r = 1'b0;
        end else begin
          pat = int'($urandom_range(1, 3));
          cs_r = (pat & 1) != 0;
          as_r = (pat & 2) != 0;
        end
        hold_left = int'($urandom_range(1, 60));
      end
      applyStimulus($urandom_range(0, 999) != 0, cs_r, as_r);
      hold_left--;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_refresh_arbiter.md
Name: dram_refresh_arbiter

Overview:
Schedules CAS-before-RAS refresh for the Mackerel-30 DRAM banks and arbitrates the DRAM between CPU bus cycles and refresh. Sits beside the DRAM access controller. CPU_GO tells the access controller it owns the array, and REF_RAS_n/REF_CAS_n are muxed onto all four RAS/CAS lines while REF_ACTIVE is high. All inputs are synchronous to CLK; synchronisers live outside this block.

Parameters:
REFRESH_INTERVAL, 780, CLK cycles between refresh requests (15.6 us at 50 MHz)
MAX_PENDING, 4, refresh debt at which refresh preempts CPU; range 1..7
CAS_SETUP, 1, cycles CAS low before RAS falls in a refresh
RAS_WIDTH, 3, cycles RAS and CAS both low during a refresh
PRECHARGE, 2, cycles both strobes high after any refresh or CPU cycle

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_n  in  1  reset; synchronous, active-low
CS_n  in  1  DRAM chip select from address decode, active-low
AS_n  in  1  CPU address strobe, active-low
CPU_GO  out  1  DRAM granted to current CPU cycle
REF_ACTIVE  out  1  refresh sequence owns the RAS/CAS lines
REF_RAS_n  out  1  refresh RAS strobe, common to all banks
REF_CAS_n  out  1  refresh CAS strobe, common to all banks
REF_PENDING  out  3  outstanding refresh count
REF_OVERFLOW  out  1  sticky: a refresh tick was lost at saturation

Behaviour:
- Reset (RST_n low at an edge): state IDLE, interval counter 0, REF_PENDING 0, REF_OVERFLOW 0, CPU_GO 0, REF_ACTIVE 0, REF_RAS_n 1, REF_CAS_n 1. Reset mid-sequence releases the strobes on that edge.
- cpu_req = !CS_n & !AS_n.
- Interval counter: counts 0..REFRESH_INTERVAL-1 and wraps. Wrap edge = tick.
- REF_PENDING updates:
  - Tick alone: +1.
  - Exit from REF_RAS alone: -1.
  - Tick and exit on the same edge: unchanged.
  - Tick when REF_PENDING==MAX_PENDING with no exit: held; REF_OVERFLOW set to 1 until reset.
- All outputs are registered. Outputs reflect the current state. Timer reloads on each state entry.
- IDLE, all outputs inactive. Priority order:
  1. REF_PENDING==MAX_PENDING -> REF_CAS.
  2. Else cpu_req -> CPU.
  3. Else REF_PENDING>0 -> REF_CAS.
  4. Else stay in IDLE.
- CPU: CPU_GO=1. Stay while cpu_req. When cpu_req drops -> CPU_PRE. A CPU cycle is never aborted by refresh, even if debt saturates.
- CPU_PRE: CPU_GO=0 for PRECHARGE cycles -> IDLE. cpu_req is ignored here.
- REF_CAS: REF_ACTIVE=1, REF_CAS_n=0, REF_RAS_n=1 for CAS_SETUP cycles -> REF_RAS.
- REF_RAS: REF_CAS_n=0, REF_RAS_n=0 for RAS_WIDTH cycles. The exit edge decrements REF_PENDING -> REF_PRE.
- REF_PRE: REF_ACTIVE=1, both strobes 1 for PRECHARGE cycles -> IDLE.
- cpu_req arriving during any REF state or CPU_PRE waits. It is granted from IDLE one cycle later.
- Latency, idle to CPU_GO: cpu_req sampled high in IDLE at edge N gives CPU_GO=1 after edge N. Worst case adds one full refresh: CAS_SETUP+RAS_WIDTH+PRECHARGE+1 cycles.
- Back-to-back refreshes: a fresh IDLE decision is made between each; a pending CPU request wins unless debt is saturated.
- CPU_GO and REF_ACTIVE are never high together. REF_RAS_n never falls while REF_CAS_n is high.
- Implementation must parameterise the interval counter width from REFRESH_INTERVAL.

Test Plan:
1. Reset then idle, REFRESH_INTERVAL=16, no CPU traffic.
   - Tick at cycle 16 sets REF_PENDING=1.
   - Next cycle REF_CAS: REF_CAS_n low 1 cycle, then RAS+CAS low 3 cycles, then 2 precharge cycles.
   - REF_PENDING returns to 0 on RAS exit.
2. CPU cycle while idle: CS_n=0, AS_n=0 for 5 cycles.
   - CPU_GO high 1 cycle after request, stays high until 1 cycle after AS_n rises.
   - 2-cycle CPU_PRE follows; no strobe activity.
3. CPU holds AS_n low across 3 ticks (REFRESH_INTERVAL=16, ~50 cycles).
   - REF_PENDING climbs to 3 with no refresh.
   - On release, after precharge: 3 consecutive refreshes, REF_PENDING 3->2->1->0.
4. Saturation with MAX_PENDING=2:
   - CPU held until 3 ticks occur; REF_PENDING stays 2 and REF_OVERFLOW=1.
   - New cpu_req in IDLE with debt 2: refresh runs first, then CPU_GO.
5. Tick on the same edge as REF_RAS exit: REF_PENDING unchanged.
6. RST_n low during REF_RAS:
   - Next edge: REF_RAS_n=1, REF_CAS_n=1, REF_ACTIVE=0, REF_PENDING=0, REF_OVERFLOW=0.
   - Interval restarts from 0.
